// File: rtl/dmem_byte_arbiter.sv
// Two-requester round-robin arbiter that sequences each 32-bit word access
// into four little-endian byte accesses on a byte-wide single-port memory.
module dmem_byte_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  output logic [31:0]       rdata0_o,
  output logic              ack0_o,
  output logic              stall0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic [31:0]       rdata1_o,
  output logic              ack1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BYTE0 = 3'd1,
    ST_BYTE1 = 3'd2,
    ST_BYTE2 = 3'd3,
    ST_BYTE3 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2'b11);

  state_t            state_q,     state_d;
  logic              owner_q,     owner_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] base_q,      base_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [23:0]       rbuf_q,      rbuf_d;
  logic              last_q,      last_d;
  logic [31:0]       rdata0_q,    rdata0_d;
  logic [31:0]       rdata1_q,    rdata1_d;
  logic              ack0_q,      ack0_d;
  logic              ack1_q,      ack1_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q,      busy_d;
  logic              grant1_s;

  // Next-state, arbitration, transaction latching and read-buffer capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant1_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie, last_q == 1 means requester 1 went last, so 0 wins.
          grant1_s = req1_i & (~req0_i | ~last_q);
          owner_d  = grant1_s;
          state_d  = ST_BYTE0;
          if (grant1_s) begin
            we_d    = we1_i;
            base_d  = addr1_i & BASE_MASK;
            wdata_d = wdata1_i;
          end else begin
            we_d    = we0_i;
            base_d  = addr0_i & BASE_MASK;
            wdata_d = wdata0_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BYTE0: begin
        state_d = ST_BYTE1;
        if (!we_q) begin
          rbuf_d[7:0] = mem_rdata_i;
        end else begin
          rbuf_d = rbuf_q;
        end
      end
      ST_BYTE1: begin
        state_d = ST_BYTE2;
        if (!we_q) begin
          rbuf_d[15:8] = mem_rdata_i;
        end else begin
          rbuf_d = rbuf_q;
        end
      end
      ST_BYTE2: begin
        state_d = ST_BYTE3;
        if (!we_q) begin
          rbuf_d[23:16] = mem_rdata_i;
        end else begin
          rbuf_d = rbuf_q;
        end
      end
      ST_BYTE3: begin
        state_d = ST_RESP;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        // The top byte goes straight into the owner's rdata on the edge into RESP.
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d = {mem_rdata_i, rbuf_q};
          end else begin
            rdata0_d = {mem_rdata_i, rbuf_q};
          end
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs are decoded from the next state so they leave flops.
  always_comb begin
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_BYTE0: begin
        mem_addr_d  = base_d;
        mem_we_d    = we_d;
        mem_wdata_d = we_d ? wdata_d[7:0] : 8'h00;
      end
      ST_BYTE1: begin
        mem_addr_d  = base_d + ADDR_W'(2'd1);
        mem_we_d    = we_d;
        mem_wdata_d = we_d ? wdata_d[15:8] : 8'h00;
      end
      ST_BYTE2: begin
        mem_addr_d  = base_d + ADDR_W'(2'd2);
        mem_we_d    = we_d;
        mem_wdata_d = we_d ? wdata_d[23:16] : 8'h00;
      end
      ST_BYTE3: begin
        mem_addr_d  = base_d + ADDR_W'(2'd3);
        mem_we_d    = we_d;
        mem_wdata_d = we_d ? wdata_d[31:24] : 8'h00;
      end
      default: begin
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = 8'h00;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      rbuf_q      <= 24'h00_0000;
      last_q      <= 1'b1;
      rdata0_q    <= 32'h0000_0000;
      rdata1_q    <= 32'h0000_0000;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      last_q      <= last_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign stall0_o    = req0_i & ~ack0_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed bench for dmem_byte_arbiter with a 32-byte behavioural memory.
`timescale 1ns/1ps
module tb_dmem_byte_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1, rdata0, rdata1;
  logic        ack0, ack1, stall0, busy;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [32];
  logic        pl_we;
  logic [4:0]  pl_addr;
  logic [7:0]  pl_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_byte_arbiter #(.ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .rdata0_o(rdata0), .ack0_o(ack0), .stall0_o(stall0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .rdata1_o(rdata1), .ack1_o(ack1),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  typedef struct {
    bit          who;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [4:0] base);
    logic [4:0] b;
    b = base & 5'b11100;
    return {mem[b + 5'd3], mem[b + 5'd2], mem[b + 5'd1], mem[b]};
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int lat, wcnt, other, stall_bad;
    logic [31:0] other_rd_before;
    lat = 0; wcnt = 0; other = 0; stall_bad = 0;
    @(negedge clk);
    other_rd_before = v.who ? rdata0 : rdata1;
    if (v.who) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    #1;
    if (!v.who) check({tag, " stall_at_req"}, {31'd0, stall0}, 32'd1);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) wcnt++;
      if ((v.who ? ack0 : ack1) === 1'b1) other++;
      if ((v.who ? ack1 : ack0) === 1'b1) lat = c;
      else if (!v.who && stall0 !== 1'b1) stall_bad++;
    end
    if (!v.who && lat != 0) check({tag, " stall_during_ack"}, {31'd0, stall0}, 32'd0);
    if (!v.who && lat != 0 && !v.we) check({tag, " rdata"}, rdata0, v.exp_rd);
    if (v.who && lat != 0 && !v.we) check({tag, " rdata"}, rdata1, v.exp_rd);
    req0 = 1'b0; req1 = 1'b0;
    check({tag, " ack_latency"}, lat, 32'd5);
    check({tag, " write_strobes"}, wcnt, v.we ? 32'd4 : 32'd0);
    check({tag, " other_ack"}, other, 32'd0);
    check({tag, " other_rdata_held"}, v.who ? rdata0 : rdata1, other_rd_before);
    if (!v.who) check({tag, " stall_held"}, stall_bad, 32'd0);
    if (v.we) check({tag, " mem_word"}, mem_word(v.addr), v.wdata);
  endtask

  initial begin
    int acks;
    vecs[0] = '{1'b0, 1'b1, 5'h04, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b0, 5'h03, 32'hFFFF_FFFF, 32'h0000_0005};
    vecs[2] = '{1'b0, 1'b0, 5'h06, 32'h0000_0000, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 5'h1C, 32'hCAFEF00D, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b0, 5'h1F, 32'h0000_0000, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 5'h14, 32'h0BADF00D, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b0, 5'h15, 32'h0000_0000, 32'h0BADF00D};
    vecs[7] = '{1'b0, 1'b1, 5'h10, 32'hA5A55A5A, 32'h0000_0000};

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 5'h00; wdata1 = 32'h0;
    pl_we = 1'b0; pl_addr = 5'h00; pl_data = 8'h00;
    #1;
    check("reset stall_follows_req", {31'd0, stall0}, 32'd1);
    check("reset ack0", {31'd0, ack0}, 32'd0);
    check("reset ack1", {31'd0, ack1}, 32'd0);
    check("reset rdata0", rdata0, 32'd0);
    check("reset rdata1", rdata1, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", {27'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    req0 = 1'b0;
    #1;
    check("reset stall_low", {31'd0, stall0}, 32'd0);

    for (int i = 0; i < 32; i++) preload(5'(i), (i == 0) ? 8'h05 : 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    check("byte_order mem4", {24'd0, mem[4]}, 32'h0000_00EF);
    check("byte_order mem7", {24'd0, mem[7]}, 32'h0000_00DE);

    // Requester 1 writes while the CPU reads the same word.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'h08; wdata1 = 32'h13572468;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("contend ack1 c%0d", c), {31'd0, ack1}, {31'd0, c == 5});
      check($sformatf("contend ack0 c%0d", c), {31'd0, ack0}, {31'd0, c == 11});
      if (c == 1) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h09; wdata0 = 32'h0;
      end
      if (c == 5) req1 = 1'b0;
      if (c == 11) begin
        check("contend rdata0", rdata0, 32'h13572468);
        req0 = 1'b0;
      end
      #1;
      check($sformatf("contend stall0 c%0d", c), {31'd0, stall0}, {31'd0, c < 11});
    end

    // Reset lands in BYTE2 of a write.
    preload(5'h08, 8'h77);
    preload(5'h09, 8'h66);
    preload(5'h0A, 8'h55);
    preload(5'h0B, 8'h99);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'h08; wdata0 = 32'h11223344;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst ack0", {31'd0, ack0}, 32'd0);
    check("midrst mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst mem_addr", {27'd0, mem_addr}, 32'd0);
    check("midrst mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("midrst rdata0", rdata0, 32'd0);
    check("midrst rdata1", rdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1 || busy === 1'b1) acks++;
    end
    check("midrst no_activity", acks, 32'd0);
    check("midrst bytes", {mem[11], mem[10], mem[9], mem[8]}, 32'h99553344);

    // Both requesters held: grants alternate starting with requester 0.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'h04;
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rr acks c%0d", c), {30'd0, ack1, ack0},
            {30'd0, (c == 11 || c == 23), (c == 5 || c == 17)});
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr rdata0", rdata0, 32'h0000_0005);
    check("rr rdata1", rdata1, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    check("rr busy_after", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_byte_arbiter.md
# dmem_byte_arbiter

Two-requester arbiter and sequencer for the byte-wide, single-port data memory of the pipelined CPU. Requester 0 is the CPU MEM stage and requester 1 is the loader/debug port. Each 32-bit word access is broken into four sequential little-endian byte accesses. The block returns a one-cycle acknowledge per transaction and drives a stall to the pipeline while the CPU waits.

## Interface
Parameters:
- ADDR_W, 5, byte-address width of the data memory (32 bytes by default).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_i  in  1  requester 0 (CPU) transaction request.
- we0_i  in  1  requester 0: 1 = write, 0 = read.
- addr0_i  in  ADDR_W  requester 0 byte address; bits [1:0] ignored.
- wdata0_i  in  32  requester 0 write word.
- rdata0_o  out  32  requester 0 read word, registered.
- ack0_o  out  1  requester 0 completion pulse.
- stall0_o  out  1  req0_i & ~ack0_o; feeds the pipeline hazard/stall logic.
- req1_i, we1_i, addr1_i, wdata1_i, rdata1_o, ack1_o: requester 1, with the same widths and meaning as requester 0.
- mem_addr_o  out  ADDR_W  byte address to memory.
- mem_we_o  out  1  byte write strobe; memory writes on the rising edge.
- mem_wdata_o  out  8  byte write data.
- mem_rdata_i  in  8  byte read data, combinational from mem_addr_o.
- busy_o  out  1  high in any state other than IDLE.

## Operation
States: IDLE, BYTE0, BYTE1, BYTE2, BYTE3, RESP.

IDLE:
- If neither request is high, remain in IDLE.
- If exactly one request is high, grant that requester.
- If both are high, grant the requester not granted last (round-robin). The last-grant pointer resets to 1, so requester 0 wins the first tie.
- On grant, latch the owner, we, base = {addr[ADDR_W-1:2], 2'b00}, and wdata; go to BYTE0.

BYTEk (k = 0..3):
- mem_addr_o = base + k, modulo 2^ADDR_W (wraps).
- Write: mem_we_o = 1 and mem_wdata_o = latched wdata[8k+7:8k].
- Read: mem_we_o = 0; capture mem_rdata_i into read-buffer byte k at the end of the cycle.
- BYTE3 goes to RESP.

RESP:
- Assert the owner's ack for one cycle.
- On a read, the owner's rdata register is loaded from the read buffer on the edge entering RESP. It is therefore valid while ack is high and holds until that owner's next read completes.
- The non-owner's rdata and ack are unaffected.
- Update the last-grant pointer to the owner; go to IDLE.

Request rules:
- A requester holds req until it sees ack, then drops req on the following edge.
- Request fields are latched at grant, so changes after grant are ignored.
- A requester that still has req high in the IDLE cycle after its RESP is treated as a new transaction.

Idle outputs: mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.

## Timing
- Reset values: state IDLE, ack0_o = ack1_o = 0, rdata0_o = rdata1_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, busy_o = 0, last-grant = 1.
- stall0_o = req0_i during reset.
- Latency: req sampled high in IDLE at cycle n → BYTE0..BYTE3 in cycles n+1..n+4 → ack in cycle n+5 → IDLE in cycle n+6. Six cycles per transaction; back-to-back throughput is one word per 6 cycles.
- A request arriving while busy waits; it is arbitrated in the next IDLE cycle.
- Simultaneous requests in IDLE are resolved by round-robin, never dropped.
- Reset mid-transaction:
  - returns immediately to IDLE with no ack;
  - bytes already written stay in memory;
  - rdata registers clear to 0.
- Address wrap: base 0x1C with ADDR_W=5 accesses bytes 0x1C–0x1F. Base + k wrap is only reachable for ADDR_W < 2 and is defined as modulo.

## Test plan
- Reset, then CPU write addr 0x04, data 0xDEADBEEF → mem bytes 4..7 = EF, BE, AD, DE; ack0_o pulses in cycle n+5; stall0_o high cycles n..n+4.
- Memory preloaded with byte0 = 0x05, CPU read addr 0x03 (low bits ignored) → rdata0_o = 32'h00000005 while ack0_o is high; no memory write strobes.
- Both requesters assert in the same cycle, held continuously: grants alternate 0, 1, 0, 1; each ack is 6 cycles apart and neither requester is starved.
- Requester 1 is busy writing when CPU requests a read → CPU waits, stall0_o stays high ~11 cycles, and the read returns the word requester 1 just wrote.
- Assert rst_i low during BYTE2 of a write of 0x11223344 to 0x08 → immediate IDLE, no ack, bytes 0x08/0x09 = 44/33, 0x0A/0x0B unchanged, all outputs at reset values.
- Write to 0x1C then read back from 0x1C → returns the written word; ack1_o is never asserted for a CPU-owned transaction.
